// File: rtl/lfsr_rr_sched_if.sv
// Requester-side bundle for lfsr_rr_sched: seeding, level requests, and the
// registered grant/word outputs.
interface lfsr_rr_sched_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  logic                  seed_load;
  logic [WIDTH-1:0]      seed;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       gnt;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  wrap;
  logic [15:0]           issued_cnt;

  modport master (
    output seed_load, seed, req,
    input  gnt, out_valid, out_data, wrap, issued_cnt
  );

  modport slave (
    input  seed_load, seed, req,
    output gnt, out_valid, out_data, wrap, issued_cnt
  );
endinterface

// File: rtl/lfsr_rr_sched.sv
// Round-robin scheduler sharing one Fibonacci LFSR among NREQ requesters;
// each grant issues the current LFSR word and advances it exactly once.
module lfsr_rr_sched #(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] TAPS         = 4'b1100,
  parameter int               NREQ         = 4,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 4'b1111
) (
  input  logic               clk,
  input  logic               rst,
  lfsr_rr_sched_if.slave     bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, HOLD} st_e;

  st_e              st_q, st_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             wrap_q, wrap_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0] lfsr_nxt;
  logic [WIDTH-1:0] seed_eff;
  logic [PW-1:0]    win;
  logic             any_req;

  assign lfsr_nxt = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
  // A zero seed would lock the LFSR at zero forever.
  assign seed_eff = (bus.seed == '0) ? SEED_DEFAULT : bus.seed;
  assign any_req  = |bus.req;

  // First set request searching upward from ptr, wrapping at NREQ.
  always_comb begin
    int   k;
    logic found;
    win   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr_q) + i) % NREQ;
      if (!found && bus.req[k]) begin
        found = 1'b1;
        win   = PW'(k);
      end
    end
  end

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    seed_d  = seed_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    vld_d   = 1'b0;
    data_d  = data_q;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    if (bus.seed_load) begin
      state_d = seed_eff;
      seed_d  = seed_eff;
      cnt_d   = '0;
      st_d    = IDLE;
    end else begin
      case (st_q)
        IDLE: begin
          if (any_req) begin
            gnt_d[win] = 1'b1;
            vld_d      = 1'b1;
            data_d     = state_q;
            state_d    = lfsr_nxt;
            wrap_d     = (lfsr_nxt == seed_q);
            cnt_d      = cnt_q + 16'd1;
            ptr_d      = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
            st_d       = HOLD;
          end
        end
        HOLD:    st_d = IDLE;
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      state_q <= SEED_DEFAULT;
      seed_q  <= SEED_DEFAULT;
      ptr_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      seed_q  <= seed_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.out_valid  = vld_q;
  assign bus.out_data   = data_q;
  assign bus.wrap       = wrap_q;
  assign bus.issued_cnt = cnt_q;
endmodule

// File: doc/lfsr_rr_sched.md
# lfsr_rr_sched

Round-robin scheduler that shares one internal Fibonacci LFSR among `NREQ` requesters, issuing one pseudo-random word per grant. It controls seeding, zero-seed lock-up protection, stepping (exactly one LFSR advance per issued word) and sequence-wrap detection. It sits between the LFSR datapath and the consumers that need random words, such as test-pattern generators and scramblers.

## Interface
- `WIDTH`, 4: LFSR/word width, must be ≥ 2.
- `TAPS`, 4'b1100: feedback mask. Feedback bit = XOR-reduce(`state & TAPS`). The default implements x^4+x^3+1, period 15.
- `NREQ`, 4: number of requesters, must be ≥ 2.
- `SEED_DEFAULT`, 4'b1111: reset seed, and the substitute seed when a zero seed is loaded. Must be nonzero.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `seed_load`  in  1  one-cycle strobe that loads `seed`.
- `seed`  in  WIDTH  seed value, sampled only when `seed_load`=1.
- `req`  in  NREQ  level requests, one bit per requester.
- `gnt`  out  NREQ  one-hot grant, registered.
- `out_valid`  out  1  one-cycle pulse marking `out_data` valid, registered.
- `out_data`  out  WIDTH  issued word, registered.
- `wrap`  out  1  pulse coincident with `out_valid`; indicates the LFSR has returned to the loaded seed.
- `issued_cnt`  out  16  count of words issued since reset or the last seed load.

## Operation
- Internal registers:
  - `state`: the LFSR.
  - `seed_reg`: the last seed loaded.
  - `ptr`: round-robin pointer, ceil(log2 `NREQ`) bits.
  - FSM: IDLE or HOLD.
- LFSR step: next = {`state`[WIDTH-2:0], ^(`state` & `TAPS`)}. The LFSR steps only on an issue edge; it never free-runs.
- Reset (`rst`=1 at an edge) sets `state` = `seed_reg` = `SEED_DEFAULT`, and `gnt`, `out_valid`, `out_data`, `wrap`, `issued_cnt`, `ptr` all to 0. The FSM goes to IDLE. Reset overrides every other input.
- Seed load (`seed_load`=1, `rst`=0), accepted in any FSM state:
  - `state` and `seed_reg` take `seed`, or `SEED_DEFAULT` if `seed`==0.
  - `gnt`, `out_valid` and `wrap` clear; `issued_cnt` clears; the FSM goes to IDLE.
  - `ptr` is unchanged.
  - `req` is ignored in that cycle.
- IDLE with |`req`=1 and no load (issue edge):
  - Winner = first set `req` bit searching upward from `ptr`, modulo `NREQ`.
  - `gnt` = onehot(winner), `out_valid`=1, `out_data`=`state`, `state`=next(`state`).
  - `wrap` = (next(`state`)==`seed_reg`).
  - `issued_cnt` increments, wrapping 0xFFFF→0.
  - `ptr` = (winner+1) mod `NREQ`.
  - FSM goes to HOLD.
- IDLE with `req`=0: all outputs hold, except that `gnt`, `out_valid` and `wrap` are 0.
- HOLD: at the next edge, `gnt`, `out_valid` and `wrap` clear and the FSM returns to IDLE. `req` is ignored during HOLD.
- Requesters must sample `out_data` while their `gnt` bit is 1. A `req` still held after its grant is re-arbitrated at the next IDLE edge under the normal round-robin rules.
- `out_data` holds its last issued value between grants.

## Timing
- Request-to-grant latency: a `req` present in an IDLE cycle produces `gnt`/`out_valid` in the next cycle.
- `gnt`, `out_valid` and `wrap` are high for exactly one cycle per issue.
- Maximum throughput: one word every 2 cycles, through the alternating IDLE/HOLD states.
- A seed load takes effect at its edge. The first issue can follow at the next edge, and its `out_data` equals the new seed.
- Simultaneous `seed_load` and `req`: the load wins, and no grant is issued at that edge.
- A seed load during HOLD aborts the HOLD and clears the active pulse outputs at that edge.
- Reset mid-operation clears the outputs at that edge; no partial grant survives.
- With defaults, `wrap` rises on every 15th issue after a load.

## Test plan
- Reset, then `req`=0001 held 3 grants → `gnt`=0001 every 2nd cycle. `out_data` = 1111, 1110, 1100. `issued_cnt`=3.
- Reset, `req`=1111 held → `gnt` sequence 0001, 0010, 0100, 1000, 0001 with data 1111, 1110, 1100, 1000, 0001.
- Load `seed`=0000 → next issue `out_data`=1111. Load `seed`=1010 on the same cycle as `req`=0100 → no `gnt` that cycle; the following grant is 0100 with `out_data`=1010.
- Reset, then 15 single-requester issues → data runs 1111, 1110, 1100, 1000, 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111. `wrap`=1 only on the 15th; the 16th issue gives 1111.
- `ptr`=2 (after a grant to requester 1), `req`=1011 → grant 1000, then 0001, then 0010.
- `rst` asserted during HOLD with `gnt`=0010 → next cycle `gnt`=0, `out_valid`=0, `issued_cnt`=0. The next issue gives `out_data`=1111 to requester 0 if requested.
